// File: rtl/btn_cmd_arbiter.sv
// btn_cmd_arbiter: button front end for the signed 4-bit LED counter.
// Three raw buttons are synchronized, debounced and turned into press/repeat
// events. Events latch into per-source pending flags, and a round-robin
// arbiter hands one command at a time to the datapath over valid/ready.

// Per-button lane: 2-flop synchronizer, debouncer, press pulse, auto-repeat.
module btn_lane #(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_CYCLES = 16,
  parameter bit RPT_EN        = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic ev
);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic           sync1, sync2, level, press, rpt;
  logic [DBW-1:0] db_cnt;
  logic           db_flip;

  // Level flips on the DB_CYCLES-th consecutive edge that sync2 disagrees.
  assign db_flip = (sync2 != level) && (db_cnt == DBW'(DB_CYCLES - 1));

  // Synchronizer, debounce counter/level and registered press pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      level  <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= db_flip & ~level;
      if ((sync2 == level) || db_flip) db_cnt <= '0;
      else                             db_cnt <= db_cnt + 1'b1;
      if (db_flip) level <= ~level;
    end
  end

  generate
    if (RPT_EN && (REPEAT_CYCLES > 0)) begin : g_rpt
      localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
      logic [RW-1:0] r_cnt;
      // Hold timer: one repeat pulse every REPEAT_CYCLES cycles of level high.
      always_ff @(posedge CLK) begin
        if (RST || !level) begin
          r_cnt <= '0;
          rpt   <= 1'b0;
        end else if (r_cnt == RW'(REPEAT_CYCLES - 1)) begin
          r_cnt <= '0;
          rpt   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          rpt   <= 1'b0;
        end
      end
    end else begin : g_norpt
      assign rpt = 1'b0;
    end
  endgenerate

  assign ev = press | rpt;
endmodule

module btn_cmd_arbiter #(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_W,
  input  logic       BTN_E,
  input  logic       BTN_N,
  input  logic       CMD_READY,
  output logic       CMD_VALID,
  output logic [1:0] CMD_OP,
  output logic       DROP
);
  localparam int NSRC = 3;
  localparam logic [1:0] SRC_W = 2'd0, SRC_E = 2'd1, SRC_N = 2'd2;

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed {
    logic       vld;
    logic [1:0] op;
  } cmd_t;

  state_t          state;
  cmd_t            cmd;
  logic [1:0]      grant, last_grant, nxt;
  logic [NSRC-1:0] btn_raw, ev, pend, acc;

  assign btn_raw = {BTN_N, BTN_E, BTN_W};

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_lane
      btn_lane #(
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .RPT_EN       (i != 2)
      ) u_lane (
        .CLK(CLK),
        .RST(RST),
        .btn(btn_raw[i]),
        .ev (ev[i])
      );
      assign acc[i] = (state == ISSUE) && CMD_READY && (grant == 2'(i));
    end
  endgenerate

  // Round robin: first pending source after the last one granted.
  always_comb begin
    nxt = SRC_N;
    case (last_grant)
      SRC_W:   nxt = pend[SRC_E] ? SRC_E : (pend[SRC_N] ? SRC_N : SRC_W);
      SRC_E:   nxt = pend[SRC_N] ? SRC_N : (pend[SRC_W] ? SRC_W : SRC_E);
      default: nxt = pend[SRC_W] ? SRC_W : (pend[SRC_E] ? SRC_E : SRC_N);
    endcase
  end

  // Pending flags; an event on a still-pending, unaccepted source is lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend <= '0;
      DROP <= 1'b0;
    end else begin
      pend <= (pend & ~acc) | ev;
      DROP <= |(ev & pend & ~acc);
    end
  end

  // Issue FSM: latch grant and opcode in IDLE, hold them until accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      grant      <= SRC_W;
      last_grant <= SRC_N;
      cmd        <= '0;
    end else begin
      case (state)
        IDLE: if (|pend) begin
          grant      <= nxt;
          last_grant <= nxt;
          cmd.vld    <= 1'b1;
          cmd.op     <= nxt + 2'd1;
          state      <= ISSUE;
        end
        ISSUE: if (CMD_READY) begin
          cmd   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign CMD_VALID = cmd.vld;
  assign CMD_OP    = cmd.op;
endmodule

// File: doc/btn_cmd_arbiter.md
# btn_cmd_arbiter

Front-end controller for the lab board's signed 4-bit LED counter. It synchronizes and debounces three push buttons and generates auto-repeat events for held buttons. Button events queue as one pending flag per source, and a round-robin arbiter issues one command at a time to the counter datapath over a valid/ready handshake. It sits between the board button pins and the counter/LED datapath, replacing ad-hoc per-button logic.

## Interface
- DB_CYCLES, 4: consecutive stable synchronized samples required to change a debounced level. Range ≥1; set to 50000 for hardware builds.
- REPEAT_CYCLES, 16: hold period per auto-repeat event for INC/DEC. 0 disables auto-repeat.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- BTN_W  in  1  raw button, asynchronous; requests INC.
- BTN_E  in  1  raw button, asynchronous; requests DEC.
- BTN_N  in  1  raw button, asynchronous; requests CLR.
- CMD_READY  in  1  datapath accepts the command this cycle.
- CMD_VALID  out  1  command presented.
- CMD_OP  out  2  01 INC, 10 DEC, 11 CLR; 00 whenever CMD_VALID=0.
- DROP  out  1  one-cycle pulse: event lost because its source was already pending.

## Operation
- Synchronizer: each BTN passes through 2 flops (sync1, sync2).
- Debouncer: one level register and one counter per source.
  - The counter increments at each edge where sync2 ≠ level, and clears to 0 at any edge where they are equal.
  - level toggles, and the counter clears, at the edge where sync2 has differed for DB_CYCLES consecutive edges, including that edge.
- Press event: registered one-cycle pulse on a debounced 0→1 level transition.
- Auto-repeat (W, E only, REPEAT_CYCLES>0):
  - A repeat counter runs while the level is 1 and clears when the level is 0.
  - Each time it reaches REPEAT_CYCLES it emits a repeat event and restarts from 0.
  - The first repeat comes REPEAT_CYCLES cycles after the press event. BTN_N never repeats.
- Pending flags pend_W, pend_E, pend_N:
  - Set by a press or repeat event; cleared when the command for that source is accepted.
  - If an event arrives in the acceptance cycle of the same source, pending stays set and DROP=0.
  - An event on an already pending source, not being accepted that cycle, is dropped: DROP=1 for that cycle. One DROP pulse covers any number of simultaneous drops.
  - Simultaneous events on different sources each set their own flag.
- Arbiter: round-robin order W→E→N→W.
  - last_grant resets to N, so W has top priority after reset.
  - The grant goes to the first pending source after last_grant in that order. last_grant updates on grant.
- FSM, 2 states:
  - IDLE: CMD_VALID=0. If any pend flag is set, register the grant and CMD_OP, then go to ISSUE.
  - ISSUE: CMD_VALID=1 with CMD_OP held stable. When CMD_READY=1, clear the granted pend flag and return to IDLE.
- The ISSUE command is never withdrawn or changed by new events or by arbitration. Only RST removes it.
- Reset values:
  - Sync flops, levels, all counters, pend flags: 0.
  - FSM: IDLE. last_grant: N.
  - CMD_VALID=0, CMD_OP=00, DROP=0.
- Reset mid-operation:
  - An ISSUE command is abandoned; CMD_VALID falls at the reset edge.
  - A button still held after reset debounces as a fresh press.

## Timing
- Press latency, with BTN high sampled first at edge k, no other pending, FSM IDLE:
  - level rises at edge k+1+DB_CYCLES.
  - Pending sets at k+2+DB_CYCLES.
  - ISSUE is entered at k+3+DB_CYCLES, so CMD_VALID is high in the cycle after that edge.
- Release follows the same debounce; release produces no command.
- Minimum command spacing: 2 cycles (ISSUE accept → IDLE → ISSUE). Back-to-back pending commands issue every 2 cycles with CMD_READY tied high.
- Glitches shorter than DB_CYCLES synchronized cycles produce no level change.
- CMD_READY is ignored in IDLE.

## Test plan
- DB_CYCLES=4, CMD_READY=1: BTN_W high from edge 10 and held 3 cycles only -> no CMD_VALID, DROP=0. Held from edge 20 -> CMD_VALID=1, CMD_OP=01 in the cycle after edge 27, for exactly one cycle.
- Simultaneous BTN_W, BTN_E, BTN_N presses after reset, CMD_READY=1 -> commands in order 01, 10, 11, each one cycle, 2 cycles apart. A second simultaneous set afterwards issues W, E, N again.
- CMD_READY=0 for 20 cycles during an ISSUE DEC -> CMD_VALID and CMD_OP=10 stable throughout. A BTN_N press meanwhile sets pend_N. After READY rises, CLR issues next.
- REPEAT_CYCLES=16, BTN_W held 60 cycles post-debounce, CMD_READY=1 -> 1 press + 3 repeat INC commands, 16 cycles apart. BTN_N held as long -> exactly 1 CLR.
- CMD_READY=0, BTN_E pressed twice, debounced, while pend_E is set -> the second event gives DROP=1 for one cycle, and only one DEC is issued after READY.
- RST asserted for 1 cycle while in ISSUE with BTN_W held -> CMD_VALID=0 and CMD_OP=00 after the reset edge. INC reissues DB_CYCLES+3 cycles after reset deasserts.
